// File: rtl/bbs_bit_collector_if.sv
// ============================================================================
// bbs_bit_collector_if : serial-bit and word handshake bundle for the collector
// Rev 1.0 ; BBS_COLLECT_PARITY_EN adds word_parity
// ============================================================================
`default_nettype none

interface bbs_bit_collector_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
);
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [N-1:0]  word_out;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] bit_count;
`ifdef BBS_COLLECT_PARITY_EN
  logic          word_parity;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, bit_count, word_parity
  );
  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, bit_count, word_parity
  );
`else
  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, bit_count
  );
  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, bit_count
  );
`endif
endinterface

`default_nettype wire

// File: rtl/bbs_bit_collector.sv
// ============================================================================
// bbs_bit_collector : LSB-first serial-in / parallel-out word collector
// Rev 1.0 ; BBS_COLLECT_PARITY_EN adds a registered word_parity output
// ============================================================================
`default_nettype none

module bbs_bit_collector #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        clr,
  bbs_bit_collector_if.slave bus
);

  typedef enum logic [0:0] {
    ST_SHIFT = 1'b0,
    ST_PEND  = 1'b1
  } state_t;

  state_t        state_q,   state_d;
  logic [N-1:0]  shifter_q, shifter_d;
  logic [CW-1:0] count_q,   count_d;
  logic [N-1:0]  word_q,    word_d;
  logic          valid_q,   valid_d;
  logic          parity_q,  parity_d;

  logic          w_accept;
  logic          w_drain;
  logic [N-1:0]  w_shifted;

  assign w_accept  = bus.bit_valid && (state_q == ST_SHIFT);
  assign w_drain   = valid_q && bus.word_ready;
  assign w_shifted = {bus.bit_in, shifter_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    count_d   = count_q;
    word_d    = word_q;
    valid_d   = valid_q;

    if (clr) begin
      state_d   = ST_SHIFT;
      shifter_d = '0;
      count_d   = '0;
      word_d    = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (w_drain) valid_d = 1'b0;
          if (w_accept) begin
            if (count_q == CW'(N - 1)) begin
              // Completed word goes straight to the slot if it is free or emptying now
              if (!valid_q || w_drain) begin
                word_d    = w_shifted;
                valid_d   = 1'b1;
                shifter_d = '0;
                count_d   = '0;
              end else begin
                shifter_d = w_shifted;
                count_d   = CW'(N);
                state_d   = ST_PEND;
              end
            end else begin
              shifter_d = w_shifted;
              count_d   = count_q + 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (w_drain) begin
            word_d    = shifter_q;
            valid_d   = 1'b1;
            shifter_d = '0;
            count_d   = '0;
            state_d   = ST_SHIFT;
          end
        end
        default: state_d = ST_SHIFT;
      endcase
    end

    // word_d only changes on a load or clear, so parity tracks word_out exactly
    parity_d = ^word_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SHIFT;
      shifter_q <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      parity_q  <= parity_d;
    end
  end

  assign bus.bit_ready  = (state_q == ST_SHIFT);
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.bit_count  = count_q;

`ifdef BBS_COLLECT_PARITY_EN
  assign bus.word_parity = parity_q;
`else
  logic w_parity_unused;
  assign w_parity_unused = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bbs_bit_collector.sv
// ============================================================================
// tb_bbs_bit_collector : scoreboard bench, directed word vectors, N = 8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bbs_bit_collector;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic clk;
  logic reset_n;
  logic clr;

  bbs_bit_collector_if #(.N(N), .CW(CW)) bus ();

  bbs_bit_collector #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          ready_drops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each call leaves bit_valid low at posedge+1 of the last accepted bit
  task automatic send_bits(input logic [N-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.bit_in    = w[i];
      bus.bit_valid = 1'b1;
      if (bus.bit_ready !== 1'b1) ready_drops++;
      @(posedge clk);
      #1;
    end
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  // Monitor: compare every drained word with the next expected entry
  always @(negedge clk) begin
    if (reset_n && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'h0, bus.word_out}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("word", {24'h0, bus.word_out}, {24'h0, e});
`ifdef BBS_COLLECT_PARITY_EN
        chk("parity", {31'h0, bus.word_parity}, {31'h0, ^e});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    clr            = 1'b0;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    ready_drops    = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_word_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("rst_word_out",   {24'h0, bus.word_out},   32'h0);
    chk("rst_bit_count",  {28'h0, bus.bit_count},  32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rst_bit_ready",  {31'h0, bus.bit_ready},  32'h1);

    // Single word, slot free: valid one cycle after the 8th accept
    bus.word_ready = 1'b1;
    exp_q.push_back(8'h8D);
    send_bits(8'h8D, 8);
    chk("lat_word_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("lat_bit_count",  {28'h0, bus.bit_count},  32'h0);
    chk("lat_word_out",   {24'h0, bus.word_out},   32'h8D);
    repeat (2) @(posedge clk); #1;

    // Backpressure: second word parks in the shifter
    bus.word_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    chk("bp_bit_ready",  {31'h0, bus.bit_ready}, 32'h0);
    chk("bp_bit_count",  {28'h0, bus.bit_count}, 32'h8);
    chk("bp_word_out",   {24'h0, bus.word_out},  32'hA5);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    chk("bp_stable_word", {24'h0, bus.word_out},  32'hA5);
    chk("bp_stable_cnt",  {28'h0, bus.bit_count}, 32'h8);
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    chk("pend_word_out",   {24'h0, bus.word_out},   32'h3C);
    chk("pend_word_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("pend_bit_ready",  {31'h0, bus.bit_ready},  32'h1);
    chk("pend_bit_count",  {28'h0, bus.bit_count},  32'h0);
    bus.word_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Sustained throughput: 64 alternating bits
    ready_drops = 0;
    for (int w = 0; w < 8; w++) exp_q.push_back(8'h55);
    for (int w = 0; w < 8; w++) send_bits(8'h55, 8);
    chk("stream_ready_drops", ready_drops, 32'h0);
    repeat (2) @(posedge clk); #1;

    // clr discards a partial word
    send_bits(8'h1F, 5);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_bit_count",  {28'h0, bus.bit_count},  32'h0);
    chk("clr_word_valid", {31'h0, bus.word_valid}, 32'h0);
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset mid-cycle with a buffered word and partial bits
    bus.word_ready = 1'b0;
    send_bits(8'h8D, 8);
    send_bits(8'h07, 3);
    chk("pre_arst_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("pre_arst_count", {28'h0, bus.bit_count},  32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_word_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("arst_word_out",   {24'h0, bus.word_out},   32'h0);
    chk("arst_bit_count",  {28'h0, bus.bit_count},  32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Parity pair (parity compared in the monitor when enabled)
    bus.word_ready = 1'b1;
    exp_q.push_back(8'h8D);
    exp_q.push_back(8'h8C);
    send_bits(8'h8D, 8);
    send_bits(8'h8C, 8);
    repeat (4) @(posedge clk); #1;

    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bbs_bit_collector.md
Name: bbs_bit_collector

Overview:
- Serial-in, parallel-out collector, the receiving end of the shift-right serial stream produced by the BBS datapath shift register.
- Accepts one pseudo-random bit per handshake, LSB-first, and assembles N-bit words.
- Completed words go into a one-entry output buffer with a valid/ready handshake. Collection of the next word continues while the buffered word waits.
- Sits between the BBS generator's serial output and the downstream word consumer (FIFO/bus interface).

Parameters:
- N, 8, word width in bits; N >= 2.
- CW, $clog2(N+1), width of the internal bit counter and bit_count output.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; highest priority after reset_n.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  collector can accept a bit this cycle.
- word_out  out  N  assembled word (output buffer contents).
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out this cycle.
- bit_count  out  CW  bits currently held in the shifter (0..N).

Behaviour:
- Reset (reset_n=0, async) and clr=1 (sync) produce the same state:
  - shifter = 0, count = 0, state = SHIFT.
  - word_out = 0, word_valid = 0, bit_count = 0.
  - bit_ready = 1 once reset_n is released.
  - Reset or clr mid-word discards all partial bits and any buffered word; no word_valid pulse follows.
- Bit accept: bit_valid && bit_ready. Word drain: word_valid && word_ready.
- Shift rule on accept: shifter <= {bit_in, shifter[N-1:1]}, count <= count+1. The first bit received ends in word bit 0, the Nth in bit N-1.
- State SHIFT:
  - bit_ready = 1.
  - Accept with count < N-1: shift only.
  - Accept with count == N-1 (word completes):
    - If the slot is free (word_valid=0) or drains this same cycle: word_out <= {bit_in, shifter[N-1:1]}, word_valid <= 1, count <= 0, shifter <= 0, stay in SHIFT.
    - Otherwise: shift, count <= N, go to PEND.
- State PEND:
  - bit_ready = 0; the shifter holds a full word.
  - On a drain: word_out <= shifter, word_valid <= 1, count <= 0, shifter <= 0, go to SHIFT. bit_ready rises the next cycle.
- Drain with no new word loaded that cycle: word_valid <= 0 and word_out holds its value.
- Latency: word_valid rises the cycle after the Nth bit is accepted (slot free).
- Throughput: one bit per cycle, sustained, whenever word_ready is held high.
- word_out is stable while word_valid=1 and word_ready=0.
- bit_in is ignored whenever bit_valid=0 or bit_ready=0.
- bit_count is the registered count; it reads N only in PEND.
- No combinational path from bit_valid to bit_ready. bit_ready depends only on state.

Optional Feature:
- Macro: BBS_COLLECT_PARITY_EN.
- Defined:
  - Adds output word_parity (1 bit) = XOR of all bits of word_out.
  - It is registered and loaded in the same cycle as word_out.
  - Reset/clr value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then with N=8 and word_ready=1, send bits 1,0,1,1,0,0,0,1 on consecutive cycles -> word_valid=1 one cycle after the 8th accept, word_out=8'h8D, bit_count=0.
- Hold word_ready=0 and stream 16 bits: first word 8'hA5 (LSB-first: 1,0,1,0,0,1,0,1), second word 8'h3C -> after the 16th bit bit_ready=0, bit_count=8, word_out=8'hA5 stable. Raise word_ready for one cycle -> next cycle word_out=8'h3C, word_valid=1, bit_ready=1.
- Continuous bit_valid=1 with word_ready=1, 64 bits of alternating 1/0 -> 8 words, each 8'h55, bit_ready never drops.
- Send 5 bits, assert clr for one cycle, then send 8 bits of 1 -> a single word 8'hFF; no word is formed from the first 5 bits.
- Assert reset_n=0 asynchronously mid-cycle while word_valid=1 and count=3 -> word_valid, word_out and bit_count go to 0 immediately, without a clock edge.
- With BBS_COLLECT_PARITY_EN defined: words 8'h8D then 8'h8C -> word_parity = 0 then 1.
